cd_color_stabilizer: RTL and testbench
======================================

// Module: cd_color_stabilizer
// PURPOSE
//  Downstream stage of the colour-detector FSM. Samples its 2-bit color code
//  (0 none, 1 red, 2 green, 3 blue) once per detection cycle and debounces it
//  over consecutive identical readings. Publishes each newly confirmed colour as
//  a valid/ready event. Keeps per-colour confirmation tallies and drives the RGB LED.
// PARAMETERS
//  SAMPLE_PERIOD  1501  clk cycles between samples (one full detector G/R/B/clear pass)
//  CONFIRM_COUNT  3     consecutive identical non-zero samples needed to confirm
//  TALLY_W        8     width of each per-colour tally counter
// PORTS
//  clk_1MHz     in   1        system clock; all logic on its posedge
//  rst_n        in   1        asynchronous, active-low reset
//  color        in   2        colour code from detector (held between updates)
//  evt_ready    in   1        consumer accepts event when high with evt_valid
//  evt_valid    out  1        confirmed-colour event pending
//  evt_color    out  2        colour of pending event (1/2/3)
//  evt_seq      out  8        event sequence number, +1 per event loaded, wraps 255->0
//  evt_ovf      out  1        sticky: an unaccepted event was overwritten
//  stable_color out  2        last confirmed colour, 0 until first confirmation
//  led_rgb      out  3        {R,G,B} one-hot of stable_color; 000 when 0
//  red_total    out  TALLY_W  red confirmations, saturating
//  green_total  out  TALLY_W  green confirmations, saturating
//  blue_total   out  TALLY_W  blue confirmations, saturating
// BEHAVIOUR
//  - Reset (async assert, sync-released use): every output 0, prescaler 0,
//    candidate 0, run_count 0. Reset mid-operation drops pending event and tallies.
//  - Prescaler counts 0..SAMPLE_PERIOD-1 and wraps; sample tick when count ==
//    SAMPLE_PERIOD-1. First tick is SAMPLE_PERIOD cycles after reset release.
//  - On tick, with s = color:
//    s==0          -> candidate<=0, run_count<=0
//    s==candidate  -> run_count<=run_count+1, saturating at CONFIRM_COUNT
//    otherwise     -> candidate<=s, run_count<=1
//  - Confirm fires in the cycle after run_count first reaches CONFIRM_COUNT, and
//    only if candidate != stable_color. A held colour confirms once; it confirms
//    again only after an intervening different or zero run.
//  - On confirm: stable_color<=candidate; matching tally +1 (holds at all-ones);
//    event loaded: evt_color<=candidate, evt_seq+1, evt_valid<=1.
//  - Handshake: evt_valid/evt_color/evt_seq stable while evt_valid & !evt_ready.
//    Transfer is evt_valid & evt_ready; evt_valid drops next cycle unless a
//    new event loads in the same cycle.
//  - Load while pending and not accepted this cycle: overwrite, set evt_ovf
//    (cleared only by reset). Load in the same cycle as a transfer: new event
//    replaces it, evt_valid stays 1, no ovf.
//  - Event FSM: S_IDLE (evt_valid=0) -> S_PEND on load. S_PEND -> S_IDLE on
//    transfer without load. S_PEND -> S_PEND on load.
//  - led_rgb combinational from stable_color: 1->100, 2->010, 3->001, 0->000.
//  - Latency: colour stable from tick k -> evt_valid at tick k+CONFIRM_COUNT-1
//    plus 1 cycle.
// STRUCTURE
//  - Shared package/header: colour codes (COL_NONE=0, COL_RED=1, COL_GREEN=2,
//    COL_BLUE=3), event FSM state encodings, default SAMPLE_PERIOD.
//  - Sub-module cd_sample_debounce: prescaler, candidate/run_count and confirm
//    pulse. Top level holds the event register/FSM, tallies and LED decode.
// TESTING (SAMPLE_PERIOD=4, CONFIRM_COUNT=3 unless noted)
//  1 reset, color=0 for 40 cycles -> all outputs 0, evt_valid never asserts
//  2 color=1 held, evt_ready=1 -> one event color=1 seq=1 one cycle after 3rd
//    tick; red_total=1; led_rgb=100; no further events while color stays 1
//  3 samples 2,2,3,2,2,2 -> single event color=2 after 6th tick; blue_total=0
//  4 evt_ready=0; confirm 1 then 3 -> evt_color=3, seq=2, evt_ovf=1, valid held
//  5 event pending; evt_ready=1 in the exact load cycle -> valid stays 1, new
//    seq shown, evt_ovf=0; next cycle with no load -> valid=0
//  6 TALLY_W=2: 4 alternating red/green confirms x2 -> totals saturate at 3;
//    rst_n low mid-run -> all outputs 0 immediately, asynchronously

Source files
------------

// File: rtl/cd_color_stabilizer_pkg.sv
// Shared definitions for the colour stabilizer: colour codes, event FSM states,
// default timing parameters and the stable-colour to LED decode.
package cd_color_stabilizer_pkg;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  // One full detector G/R/B/clear pass at 1 MHz
  localparam int DEFAULT_SAMPLE_PERIOD = 1501;
  localparam int DEFAULT_CONFIRM_COUNT = 3;
  localparam int DEFAULT_TALLY_W       = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } evt_state_e;

  function automatic logic [2:0] color_to_led(input logic [1:0] c);
    logic [2:0] led;
    case (c)
      COL_RED:   led = 3'b100;
      COL_GREEN: led = 3'b010;
      COL_BLUE:  led = 3'b001;
      default:   led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/cd_sample_debounce.sv
// Samples the detector colour once per SAMPLE_PERIOD and pulses o_confirm for one
// cycle when a non-zero colour has been seen CONFIRM_COUNT times in a row.
module cd_sample_debounce
  import cd_color_stabilizer_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
  parameter int CONFIRM_COUNT = DEFAULT_CONFIRM_COUNT
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [1:0] i_color,
  output logic [1:0] o_candidate,
  output logic       o_confirm
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int RW = $clog2(CONFIRM_COUNT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(CONFIRM_COUNT);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_candidate;
  logic [RW-1:0] r_runCount;
  logic          r_confirm;

  logic          w_tick;
  logic          w_same;
  logic [RW-1:0] w_nextRun;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_same = (i_color == r_candidate);

  always_comb begin
    w_nextRun = r_runCount;
    if (i_color == COL_NONE) begin
      w_nextRun = '0;
    end else if (w_same) begin
      w_nextRun = (r_runCount == RUN_MAX) ? RUN_MAX : r_runCount + RW'(1);
    end else begin
      w_nextRun = RW'(1);
    end
  end

  // In every branch the new candidate equals the sample itself, so it is loaded
  // unconditionally; the confirm pulse marks only the first arrival at RUN_MAX.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_candidate <= COL_NONE;
      r_runCount  <= '0;
      r_confirm   <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_confirm <= 1'b0;
      if (w_tick) begin
        r_candidate <= i_color;
        r_runCount  <= w_nextRun;
        r_confirm   <= (w_nextRun == RUN_MAX) && !(w_same && (r_runCount == RUN_MAX));
      end
    end
  end

  assign o_candidate = r_candidate;
  assign o_confirm   = r_confirm;

endmodule

// File: rtl/cd_color_stabilizer.sv
// Debounced colour stage: turns confirmed colours into valid/ready events,
// keeps saturating per-colour tallies and drives the RGB LED.
module cd_color_stabilizer
  import cd_color_stabilizer_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
  parameter int CONFIRM_COUNT = DEFAULT_CONFIRM_COUNT,
  parameter int TALLY_W       = DEFAULT_TALLY_W
) (
  input  logic               clk_1MHz,
  input  logic               rst_n,
  input  logic [1:0]         color,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [1:0]         evt_color,
  output logic [7:0]         evt_seq,
  output logic               evt_ovf,
  output logic [1:0]         stable_color,
  output logic [2:0]         led_rgb,
  output logic [TALLY_W-1:0] red_total,
  output logic [TALLY_W-1:0] green_total,
  output logic [TALLY_W-1:0] blue_total
);

  logic [1:0] w_candidate;
  logic       w_confirm;
  logic       w_load;
  evt_state_e r_state;

  cd_sample_debounce #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .CONFIRM_COUNT(CONFIRM_COUNT)
  ) u_debounce (
    .clk_1MHz   (clk_1MHz),
    .rst_n      (rst_n),
    .i_color    (color),
    .o_candidate(w_candidate),
    .o_confirm  (w_confirm)
  );

  // A run of the colour already on display is not news and is dropped here
  assign w_load = w_confirm && (w_candidate != stable_color);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      evt_valid <= 1'b0;
      evt_color <= COL_NONE;
      evt_seq   <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_state   <= S_PEND;
            evt_valid <= 1'b1;
            evt_color <= w_candidate;
            evt_seq   <= evt_seq + 8'd1;
          end
        end
        S_PEND: begin
          if (w_load) begin
            if (!evt_ready) evt_ovf <= 1'b1;
            evt_valid <= 1'b1;
            evt_color <= w_candidate;
            evt_seq   <= evt_seq + 8'd1;
          end else if (evt_ready) begin
            r_state   <= S_IDLE;
            evt_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      stable_color <= COL_NONE;
      red_total    <= '0;
      green_total  <= '0;
      blue_total   <= '0;
    end else if (w_load) begin
      stable_color <= w_candidate;
      case (w_candidate)
        COL_RED:   if (red_total   != '1) red_total   <= red_total   + TALLY_W'(1);
        COL_GREEN: if (green_total != '1) green_total <= green_total + TALLY_W'(1);
        COL_BLUE:  if (blue_total  != '1) blue_total  <= blue_total  + TALLY_W'(1);
        default: ;
      endcase
    end
  end

  assign led_rgb = color_to_led(stable_color);

endmodule

// File: tb/tb_cd_color_stabilizer.sv
// Bench for cd_color_stabilizer: two instances (8-bit and 2-bit tallies) driven
// with the same directed stimulus, checked every cycle against a sample-history model.
module tb_cd_color_stabilizer;

  localparam int SP = 4;
  localparam int CC = 3;

  logic       clk_1MHz = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] colorIn  = 2'd0;
  logic       evtReady = 1'b0;

  logic       o8Valid, o2Valid, o8Ovf, o2Ovf;
  logic [1:0] o8Color, o2Color, o8Stable, o2Stable;
  logic [7:0] o8Seq, o2Seq;
  logic [2:0] o8Led, o2Led;
  logic [7:0] o8Red, o8Green, o8Blue;
  logic [1:0] o2Red, o2Green, o2Blue;

  int total = 0;
  int bad   = 0;

  // Model state: expected register contents after the most recent clock edge
  int         mHist[$];
  int         mEdges = 0;
  bit         mPending = 1'b0;
  int         mPendColor = 0;
  bit         mValid = 1'b0;
  int         mColor = 0;
  logic [7:0] mSeq = 8'd0;
  bit         mOvf = 1'b0;
  int         mStable = 0;
  int         mRed = 0, mGreen = 0, mBlue = 0;

  cd_color_stabilizer #(.SAMPLE_PERIOD(SP), .CONFIRM_COUNT(CC), .TALLY_W(8)) dut8 (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .color(colorIn), .evt_ready(evtReady),
    .evt_valid(o8Valid), .evt_color(o8Color), .evt_seq(o8Seq), .evt_ovf(o8Ovf),
    .stable_color(o8Stable), .led_rgb(o8Led),
    .red_total(o8Red), .green_total(o8Green), .blue_total(o8Blue)
  );

  cd_color_stabilizer #(.SAMPLE_PERIOD(SP), .CONFIRM_COUNT(CC), .TALLY_W(2)) dut2 (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .color(colorIn), .evt_ready(evtReady),
    .evt_valid(o2Valid), .evt_color(o2Color), .evt_seq(o2Seq), .evt_ovf(o2Ovf),
    .stable_color(o2Stable), .led_rgb(o2Led),
    .red_total(o2Red), .green_total(o2Green), .blue_total(o2Blue)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satTo(input int n, input int maxVal);
    return (n > maxVal) ? maxVal : n;
  endfunction

  function automatic int ledOf(input int c);
    case (c)
      1: return 4;
      2: return 2;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  // Length of the run of identical samples at the end of the history window
  function automatic int trailingRun();
    int n = 0;
    int last;
    if (mHist.size() == 0) return 0;
    last = mHist[mHist.size()-1];
    for (int i = mHist.size()-1; i >= 0; i--) begin
      if (mHist[i] == last) n++;
      else break;
    end
    return n;
  endfunction

  task automatic modelReset();
    mHist.delete();
    mEdges = 0; mPending = 1'b0; mPendColor = 0;
    mValid = 1'b0; mColor = 0; mSeq = 8'd0; mOvf = 1'b0; mStable = 0;
    mRed = 0; mGreen = 0; mBlue = 0;
  endtask

  // One clock edge: publish a confirmation found at the previous sample, run
  // the handshake, then take a new sample if this edge ends a sample period.
  task automatic modelStep();
    int s;
    if (mPending && (mPendColor != mStable)) begin
      if (mValid && !evtReady) mOvf = 1'b1;
      mValid  = 1'b1;
      mColor  = mPendColor;
      mSeq    = mSeq + 8'd1;
      mStable = mPendColor;
      if (mPendColor == 1) mRed++;
      if (mPendColor == 2) mGreen++;
      if (mPendColor == 3) mBlue++;
    end else if (mValid && evtReady) begin
      mValid = 1'b0;
    end
    mPending = 1'b0;
    if ((mEdges % SP) == SP - 1) begin
      s = int'(colorIn);
      mHist.push_back(s);
      if (mHist.size() > CC + 1) void'(mHist.pop_front());
      if (s != 0 && trailingRun() == CC) begin
        mPending   = 1'b1;
        mPendColor = s;
      end
    end
    mEdges++;
  endtask

  initial begin : modelProc
    forever begin
      @(posedge clk_1MHz or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  task automatic compareDut(input string tag, input int satMax, input logic v,
                            input logic [1:0] c, input logic [7:0] s, input logic o,
                            input logic [1:0] st, input logic [2:0] led,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    checkOutput({tag, "_valid"},  32'(v),   32'(mValid));
    checkOutput({tag, "_ovf"},    32'(o),   32'(mOvf));
    checkOutput({tag, "_seq"},    32'(s),   32'(mSeq));
    checkOutput({tag, "_stable"}, 32'(st),  mStable);
    checkOutput({tag, "_led"},    32'(led), ledOf(mStable));
    checkOutput({tag, "_red"},    32'(r),   satTo(mRed, satMax));
    checkOutput({tag, "_green"},  32'(g),   satTo(mGreen, satMax));
    checkOutput({tag, "_blue"},   32'(b),   satTo(mBlue, satMax));
    if (mValid) checkOutput({tag, "_color"}, 32'(c), mColor);
  endtask

  initial begin : compareProc
    forever begin
      @(negedge clk_1MHz);
      compareDut("w8", 255, o8Valid, o8Color, o8Seq, o8Ovf, o8Stable, o8Led,
                 o8Red, o8Green, o8Blue);
      compareDut("w2", 3, o2Valid, o2Color, o2Seq, o2Ovf, o2Stable, o2Led,
                 {6'b0, o2Red}, {6'b0, o2Green}, {6'b0, o2Blue});
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_1MHz);
  endtask

  // Holds a colour for a whole number of sample periods, keeping tick alignment
  task automatic applyStimulus(input logic [1:0] c, input logic rdy, input int samples);
    colorIn  = c;
    evtReady = rdy;
    waitCycles(samples * SP);
  endtask

  task automatic doReset();
    @(posedge clk_1MHz);
    #1 rst_n = 1'b0;
    colorIn  = 2'd0;
    evtReady = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
  endtask

  initial begin : mainProc
    int seen;

    // Idle input: nothing may ever be published
    doReset();
    evtReady = 1'b1;
    seen = 0;
    repeat (10 * SP) begin
      @(negedge clk_1MHz);
      if (o8Valid || o2Valid) seen++;
    end
    checkOutput("p1_no_event", seen, 0);
    checkOutput("p1_stable", 32'(o8Stable), 0);

    // Held red confirms exactly once, one cycle after the third tick
    applyStimulus(2'd1, 1'b1, 3);
    checkOutput("p2_not_yet", 32'(o8Valid), 0);
    waitCycles(1);
    checkOutput("p2_valid", 32'(o8Valid), 1);
    checkOutput("p2_color", 32'(o8Color), 1);
    checkOutput("p2_seq", 32'(o8Seq), 1);
    checkOutput("p2_red", 32'(o8Red), 1);
    checkOutput("p2_led", 32'(o8Led), 32'h4);
    waitCycles(1);
    checkOutput("p2_accepted", 32'(o8Valid), 0);
    waitCycles(SP - 2);
    applyStimulus(2'd1, 1'b1, 5);
    checkOutput("p2_no_repeat", 32'(o8Seq), 1);

    // Interrupted green run: only the final three-in-a-row confirms
    applyStimulus(2'd2, 1'b1, 2);
    applyStimulus(2'd3, 1'b1, 1);
    checkOutput("p3_no_early", 32'(o8Seq), 1);
    applyStimulus(2'd2, 1'b1, 3);
    waitCycles(1);
    checkOutput("p3_valid", 32'(o8Valid), 1);
    checkOutput("p3_color", 32'(o8Color), 2);
    checkOutput("p3_seq", 32'(o8Seq), 2);
    checkOutput("p3_blue", 32'(o8Blue), 0);
    checkOutput("p3_led", 32'(o8Led), 32'h2);
    waitCycles(SP - 1);

    // Consumer stalled: second event overwrites the first and flags overflow
    doReset();
    applyStimulus(2'd1, 1'b0, 3);
    waitCycles(1);
    checkOutput("p4_first_color", 32'(o8Color), 1);
    checkOutput("p4_first_ovf", 32'(o8Ovf), 0);
    waitCycles(SP - 1);
    applyStimulus(2'd3, 1'b0, 3);
    waitCycles(1);
    checkOutput("p4_color", 32'(o8Color), 3);
    checkOutput("p4_seq", 32'(o8Seq), 2);
    checkOutput("p4_ovf", 32'(o8Ovf), 1);
    waitCycles(SP - 1);
    checkOutput("p4_held", 32'(o8Valid), 1);

    // Accept in the very cycle a new event loads: replace, no overflow
    doReset();
    applyStimulus(2'd2, 1'b0, 3);
    waitCycles(1);
    checkOutput("p5_pending", 32'(o8Valid), 1);
    waitCycles(SP - 1);
    applyStimulus(2'd1, 1'b0, 3);
    checkOutput("p5_still_old", 32'(o8Color), 2);
    evtReady = 1'b1;
    waitCycles(1);
    checkOutput("p5_valid", 32'(o8Valid), 1);
    checkOutput("p5_color", 32'(o8Color), 1);
    checkOutput("p5_seq", 32'(o8Seq), 2);
    checkOutput("p5_ovf", 32'(o8Ovf), 0);
    waitCycles(1);
    checkOutput("p5_drop", 32'(o8Valid), 0);
    waitCycles(SP - 2);

    // Eight alternating red/green confirms: 2-bit tallies pin at 3
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 3);
    waitCycles(2);
    checkOutput("p6_red8", 32'(o8Red), 4);
    checkOutput("p6_green8", 32'(o8Green), 4);
    checkOutput("p6_red2", 32'(o2Red), 3);
    checkOutput("p6_green2", 32'(o2Green), 3);
    checkOutput("p6_seq", 32'(o2Seq), 8);
    @(posedge clk_1MHz);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("p6_async_stable", 32'(o8Stable), 0);
    checkOutput("p6_async_led", 32'(o2Led), 0);
    checkOutput("p6_async_red2", 32'(o2Red), 0);
    checkOutput("p6_async_green8", 32'(o8Green), 0);
    checkOutput("p6_async_seq", 32'(o8Seq), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2 * SP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
